dual_stream_tx: RTL and testbench
=================================

Name: dual_stream_tx

Overview:
- Two-lane packet transmitter that drives the source side of the two-lane stream synchronizer: per lane, data + write strobe + last, plus ready.
- Upstream writes bytes into a small FIFO per lane. A packet is released only when both lanes hold a complete packet.
- Both packets are played out, then ready is held until the synchronizer's completion pulse arrives.

Parameters:
- DEPTH, 16, per-lane FIFO depth in words; power of 2, 4..256.
- AW, 4, log2(DEPTH).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_data1  in  8  lane-1 write data.
- in_wr1  in  1  lane-1 write strobe.
- in_last1  in  1  marks the final byte of a lane-1 packet; qualified by in_wr1.
- in_full1  out  1  lane-1 FIFO full.
- in_data2, in_wr2, in_last2, in_full2: same as lane 1, for lane 2.
- tx_data1  out  8  lane-1 output byte.
- tx_en1  out  1  lane-1 byte strobe.
- tx_last1  out  1  lane-1 last byte, coincident with tx_en1.
- tx_data2, tx_en2, tx_last2: same as lane 1, for lane 2.
- tx_ready1  out  1  lane-1 ready toward the synchronizer.
- tx_ready2  out  1  lane-2 ready toward the synchronizer.
- done_i  in  1  one-cycle completion pulse from the synchronizer.
- busy  out  1  high in any state except IDLE.
- ovf  out  1  sticky write-while-full error.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0 (tx_data*=8'h00); FIFO pointers, packet counters and FSM cleared; FIFO contents need not be cleared.
  - Reset mid-packet discards all buffered data.
- FIFO, per lane:
  - DEPTH x 9 bits (data + last flag); wr/rd pointers are AW+1 bits.
  - full = (ptr MSBs differ && low bits equal); in_full = full.
  - A write when full is dropped and sets ovf, which stays set until reset.
  - Read and write in the same cycle are both honoured.
- Packet counter, per lane: AW+1 bits.
  - +1 on an accepted write with in_last.
  - -1 when that lane emits tx_last.
  - Simultaneous +1 and -1 leave the counter unchanged.
- FSM states: IDLE, SEND, WAIT_DONE.
  - IDLE -> SEND when pkt_cnt1!=0 && pkt_cnt2!=0.
  - SEND:
    - Each lane with lane_done=0 pops one word per cycle; tx_data <= head data, tx_en <= 1, tx_last <= head last flag.
    - Outputs are registered: the first tx_en is seen the cycle after entering SEND.
    - After popping its last-flagged word, a lane sets lane_done and its tx_en drops on the next cycle.
    - Lanes run independently, so unequal lengths are allowed; the shorter lane idles at tx_en=0.
  - SEND -> WAIT_DONE the cycle after both lane_done flags are set.
    - Both tx_en are 0 on entry; tx_ready1 = tx_ready2 = 1.
  - WAIT_DONE -> IDLE on done_i=1: clear readys and lane_done flags.
    - done_i outside WAIT_DONE is ignored.
- Packet length is unbounded by the FSM but limited by DEPTH. A lane whose FIFO is full with pkt_cnt=0 cannot progress; preventing that is upstream's obligation.
- Writes are accepted in every state, including while that lane is being read.

Optional Feature:
- Macro: DUAL_STREAM_TX_TIMEOUT_EN.
- Defined:
  - Adds a parameter TIMEOUT (default 1024) and an output timeout_o (1 bit, reset 0).
  - A 16-bit counter runs in WAIT_DONE. When it reaches TIMEOUT-1 with no done_i: go to IDLE, drop readys, pulse timeout_o for one cycle.
  - done_i on the same cycle as expiry wins; no pulse is produced.
- Undefined: no timeout_o port and no counter; WAIT_DONE waits indefinitely.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random inputs -> all outputs 0, busy=0.
- Basic pair:
  - Stimulus: lane 1 bytes 0x11,0x22,0x33 (last on 0x33); lane 2 bytes 0xA0,0xA1 (last on 0xA1).
  - Response: tx_en1 high for 3 consecutive cycles and tx_en2 for 2, both starting together.
  - tx_last1 on 0x33 and tx_last2 on 0xA1; then readys=1 until done_i; busy=0 the cycle after done_i.
- Single-lane hold: lane 1 packet only -> no tx_en for 50 cycles. Then write lane 2 byte 0x5A with last -> transmission starts.
- Full/overflow: with DEPTH=16, write 17 bytes to lane 1 without last -> in_full1=1 after the 16th write, ovf=1 after the 17th, and the 17th byte is never emitted.
- Back-to-back: queue 2 packets per lane, one done_i per round -> two SEND rounds in order; pkt_cnt returns to 0.
- Timeout (macro defined, TIMEOUT=8): withhold done_i -> exactly 8 cycles in WAIT_DONE, timeout_o pulses once, FSM in IDLE.

Source files
------------

// File: rtl/dual_stream_tx.sv
// rtl/dual_stream_tx.sv - two-lane packet transmitter feeding a two-lane stream synchronizer
//
// Each lane buffers upstream bytes (with a last flag) in a DEPTH-word FIFO.
// A round starts only when both lanes hold at least one complete packet.
// One packet per lane is then played out, and ready is held toward the
// synchronizer until it returns its completion pulse.
//
// Optional feature macro: DUAL_STREAM_TX_TIMEOUT_EN
//   When defined, adds parameter TIMEOUT and output timeout_o. WAIT_DONE is
//   abandoned after TIMEOUT cycles without done_i, and timeout_o pulses once.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   in_data*/in_wr*/in_last* upstream byte write per lane; in_full* = FIFO full
//   tx_data*/tx_en*/tx_last* registered output byte stream per lane
//   tx_ready1/tx_ready2      high while waiting for the synchronizer
//   done_i                   one-cycle completion pulse from the synchronizer
//   busy                     FSM not in IDLE
//   ovf                      sticky write-while-full error
//   timeout_o                (macro only) one-cycle WAIT_DONE expiry pulse

module dual_stream_tx #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
`ifdef DUAL_STREAM_TX_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1024
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data1,
    input  logic       in_wr1,
    input  logic       in_last1,
    output logic       in_full1,
    input  logic [7:0] in_data2,
    input  logic       in_wr2,
    input  logic       in_last2,
    output logic       in_full2,
    output logic [7:0] tx_data1,
    output logic       tx_en1,
    output logic       tx_last1,
    output logic [7:0] tx_data2,
    output logic       tx_en2,
    output logic       tx_last2,
    output logic       tx_ready1,
    output logic       tx_ready2,
    input  logic       done_i,
    output logic       busy,
`ifdef DUAL_STREAM_TX_TIMEOUT_EN
    output logic       timeout_o,
`endif
    output logic       ovf
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Per-lane state; index 0 is lane 1, index 1 is lane 2.
    logic [AW:0] wr_ptr_q  [2];
    logic [AW:0] wr_ptr_d  [2];
    logic [AW:0] rd_ptr_q  [2];
    logic [AW:0] rd_ptr_d  [2];
    logic [AW:0] pkt_cnt_q [2];
    logic [AW:0] pkt_cnt_d [2];
    logic        lane_done_q [2];
    logic        lane_done_d [2];
    logic        tx_en_q   [2];
    logic        tx_en_d   [2];
    logic        tx_last_q [2];
    logic        tx_last_d [2];
    logic [7:0]  tx_data_q [2];
    logic [7:0]  tx_data_d [2];
    logic        ready_q, ready_d;
    logic        ovf_q, ovf_d;

    // Storage: {last, data}; contents are not reset.
    logic [8:0]  mem [2][DEPTH];

    logic [7:0]  wr_data [2];
    logic        wr_en   [2];
    logic        wr_last [2];
    logic        full    [2];
    logic        empty   [2];
    logic        wr_acc  [2];
    logic        pop     [2];
    logic [8:0]  head    [2];

    assign wr_data[0] = in_data1;
    assign wr_data[1] = in_data2;
    assign wr_en[0]   = in_wr1;
    assign wr_en[1]   = in_wr2;
    assign wr_last[0] = in_last1;
    assign wr_last[1] = in_last2;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            full[i]   = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                        (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
            empty[i]  = (wr_ptr_q[i] == rd_ptr_q[i]);
            wr_acc[i] = wr_en[i] && !full[i];
            head[i]   = mem[i][rd_ptr_q[i][AW-1:0]];
            // The empty guard only matters if upstream breaks the packet
            // contract; a counted packet is always fully buffered.
            pop[i]    = (state_q == SEND) && !lane_done_q[i] && !empty[i];
        end
    end

`ifdef DUAL_STREAM_TX_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        timeout_q, timeout_d;
    logic        expire;

    // done_i is excluded so that a completion on the expiry cycle wins.
    assign expire = (state_q == WAIT_DONE) && !done_i &&
                    (tmo_cnt_q == 16'(TIMEOUT - 1));
`endif

    // FSM next state and ready.
    always_comb begin
        state_d = state_q;
`ifdef DUAL_STREAM_TX_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pkt_cnt_q[0] != '0 && pkt_cnt_q[1] != '0) state_d = SEND;
            end
            SEND: begin
                if (lane_done_q[0] && lane_done_q[1]) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_i) begin
                    state_d = IDLE;
                end
`ifdef DUAL_STREAM_TX_TIMEOUT_EN
                else if (expire) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == WAIT_DONE);
    end

`ifdef DUAL_STREAM_TX_TIMEOUT_EN
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == WAIT_DONE && state_d == WAIT_DONE) tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
`endif

    // Per-lane datapath next state.
    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < 2; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + (AW+1)'(wr_acc[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + (AW+1)'(pop[i]);

            // Count completes on accepted last-writes, retire on emitted tx_last.
            pkt_cnt_d[i] = pkt_cnt_q[i];
            if ((wr_acc[i] && wr_last[i]) && !(tx_en_q[i] && tx_last_q[i]))
                pkt_cnt_d[i] = pkt_cnt_q[i] + 1'b1;
            else if (!(wr_acc[i] && wr_last[i]) && (tx_en_q[i] && tx_last_q[i]))
                pkt_cnt_d[i] = pkt_cnt_q[i] - 1'b1;

            tx_en_d[i]   = pop[i];
            tx_last_d[i] = pop[i] && head[i][8];
            tx_data_d[i] = pop[i] ? head[i][7:0] : 8'h00;

            if (state_d == IDLE) lane_done_d[i] = 1'b0;
            else                 lane_done_d[i] = lane_done_q[i] || (pop[i] && head[i][8]);

            if (wr_en[i] && full[i]) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i]    <= '0;
                rd_ptr_q[i]    <= '0;
                pkt_cnt_q[i]   <= '0;
                lane_done_q[i] <= 1'b0;
                tx_en_q[i]     <= 1'b0;
                tx_last_q[i]   <= 1'b0;
                tx_data_q[i]   <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i]    <= wr_ptr_d[i];
                rd_ptr_q[i]    <= rd_ptr_d[i];
                pkt_cnt_q[i]   <= pkt_cnt_d[i];
                lane_done_q[i] <= lane_done_d[i];
                tx_en_q[i]     <= tx_en_d[i];
                tx_last_q[i]   <= tx_last_d[i];
                tx_data_q[i]   <= tx_data_d[i];
            end
        end
    end

`ifdef DUAL_STREAM_TX_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`endif

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (wr_acc[i]) mem[i][wr_ptr_q[i][AW-1:0]] <= {wr_last[i], wr_data[i]};
        end
    end

    assign in_full1  = full[0];
    assign in_full2  = full[1];
    assign tx_data1  = tx_data_q[0];
    assign tx_en1    = tx_en_q[0];
    assign tx_last1  = tx_last_q[0];
    assign tx_data2  = tx_data_q[1];
    assign tx_en2    = tx_en_q[1];
    assign tx_last2  = tx_last_q[1];
    assign tx_ready1 = ready_q;
    assign tx_ready2 = ready_q;
    assign busy      = (state_q != IDLE);
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_dual_stream_tx.sv
// tb/tb_dual_stream_tx.sv - directed self-checking bench for dual_stream_tx

module tb_dual_stream_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data1, in_data2;
    logic       in_wr1, in_wr2, in_last1, in_last2;
    logic       done_i;
    logic       in_full1, in_full2;
    logic [7:0] tx_data1, tx_data2;
    logic       tx_en1, tx_en2, tx_last1, tx_last2;
    logic       tx_ready1, tx_ready2, busy, ovf;
`ifdef DUAL_STREAM_TX_TIMEOUT_EN
    logic       timeout_o;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Captured output beats {last, data} and the cycle they appeared in.
    logic [8:0] q1[$];
    logic [8:0] q2[$];
    int         c1[$];
    int         c2[$];

    always #5 clk = ~clk;

    dual_stream_tx #(
        .DEPTH(16),
        .AW(4)
`ifdef DUAL_STREAM_TX_TIMEOUT_EN
        ,
        .TIMEOUT(8)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data1(in_data1),
        .in_wr1(in_wr1),
        .in_last1(in_last1),
        .in_full1(in_full1),
        .in_data2(in_data2),
        .in_wr2(in_wr2),
        .in_last2(in_last2),
        .in_full2(in_full2),
        .tx_data1(tx_data1),
        .tx_en1(tx_en1),
        .tx_last1(tx_last1),
        .tx_data2(tx_data2),
        .tx_en2(tx_en2),
        .tx_last2(tx_last2),
        .tx_ready1(tx_ready1),
        .tx_ready2(tx_ready2),
        .done_i(done_i),
        .busy(busy),
`ifdef DUAL_STREAM_TX_TIMEOUT_EN
        .timeout_o(timeout_o),
`endif
        .ovf(ovf)
    );

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            if (tx_en1) begin
                q1.push_back({tx_last1, tx_data1});
                c1.push_back(cyc);
            end
            if (tx_en2) begin
                q2.push_back({tx_last2, tx_data2});
                c2.push_back(cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int lane, input logic [7:0] d, input logic l);
        if (lane == 1) begin
            in_data1 = d; in_wr1 = 1'b1; in_last1 = l;
        end else begin
            in_data2 = d; in_wr2 = 1'b1; in_last2 = l;
        end
        @(posedge clk); #1;
        in_wr1 = 1'b0; in_wr2 = 1'b0; in_last1 = 1'b0; in_last2 = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!tx_ready1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_rdy"}, {31'd0, tx_ready1}, 32'd1);
    endtask

    task automatic pulse_done();
        done_i = 1'b1;
        @(posedge clk); #1;
        done_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_data1 = 8'($urandom); in_data2 = 8'($urandom);
            in_wr1 = 1'($urandom);   in_wr2 = 1'($urandom);
            in_last1 = 1'($urandom); in_last2 = 1'($urandom);
            done_i = 1'($urandom);
            @(posedge clk); #1;
        end
        in_data1 = 8'h00; in_data2 = 8'h00;
        in_wr1 = 1'b0; in_wr2 = 1'b0; in_last1 = 1'b0; in_last2 = 1'b0;
        done_i = 1'b0;
    endtask

    initial begin
        int b1, b2;

        // Reset with random inputs
        do_reset();
        check("rst_out", {5'd0, tx_data1, tx_data2, tx_en1, tx_en2, tx_last1, tx_last2,
                          tx_ready1, tx_ready2, in_full1, in_full2, ovf}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic pair
        b1 = q1.size(); b2 = q2.size();
        wr(1, 8'h11, 1'b0); wr(1, 8'h22, 1'b0); wr(1, 8'h33, 1'b1);
        wr(2, 8'hA0, 1'b0); wr(2, 8'hA1, 1'b1);
        wait_ready("basic");
        check("basic_n1", q1.size() - b1, 32'd3);
        check("basic_n2", q2.size() - b2, 32'd2);
        check("basic_l1_0", {23'd0, q1[b1]},   32'h011);
        check("basic_l1_1", {23'd0, q1[b1+1]}, 32'h022);
        check("basic_l1_2", {23'd0, q1[b1+2]}, 32'h133);
        check("basic_l2_0", {23'd0, q2[b2]},   32'h0A0);
        check("basic_l2_1", {23'd0, q2[b2+1]}, 32'h1A1);
        check("basic_start", c1[b1] - c2[b2], 32'd0);
        check("basic_run1", c1[b1+2] - c1[b1], 32'd2);
        check("basic_run2", c2[b2+1] - c2[b2], 32'd1);
        check("basic_en_off", {30'd0, tx_en1, tx_en2}, 32'd0);
        repeat (5) begin @(posedge clk); #1; end
        check("basic_hold", {29'd0, tx_ready1, tx_ready2, busy}, 32'd7);
        pulse_done();
        check("basic_post", {29'd0, tx_ready1, tx_ready2, busy}, 32'd0);

        // Single-lane hold
        b1 = q1.size(); b2 = q2.size();
        wr(1, 8'h77, 1'b1);
        repeat (50) begin @(posedge clk); #1; end
        check("hold_none", q1.size() - b1, 32'd0);
        check("hold_busy", {31'd0, busy}, 32'd0);
        wr(2, 8'h5A, 1'b1);
        wait_ready("hold");
        check("hold_l1", {23'd0, q1[b1]}, 32'h177);
        check("hold_l2", {23'd0, q2[b2]}, 32'h15A);
        pulse_done();

        // Full / overflow on lane 1
        b1 = q1.size();
        for (int i = 0; i < 17; i++) begin
            wr(1, 8'(8'hC0 + i), 1'b0);
            if (i == 14) check("ovf_full15", {31'd0, in_full1}, 32'd0);
            if (i == 15) check("ovf_full16", {30'd0, in_full1, ovf}, 32'd2);
            if (i == 16) check("ovf_set17", {30'd0, in_full1, ovf}, 32'd3);
        end
        wr(2, 8'h99, 1'b1);
        repeat (20) begin @(posedge clk); #1; end
        check("ovf_stuck", q1.size() - b1, 32'd0);
        check("ovf_sticky", {30'd0, ovf, busy}, 32'd2);
        do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        check("ovf_clr", {30'd0, ovf, in_full1}, 32'd0);

        // Back-to-back: two packets per lane
        b1 = q1.size(); b2 = q2.size();
        wr(1, 8'h01, 1'b0); wr(1, 8'h02, 1'b1); wr(1, 8'h03, 1'b1);
        wr(2, 8'h10, 1'b1); wr(2, 8'h20, 1'b0); wr(2, 8'h21, 1'b0); wr(2, 8'h22, 1'b1);
        wait_ready("b2b_r1");
        check("b2b_r1_n1", q1.size() - b1, 32'd2);
        check("b2b_r1_n2", q2.size() - b2, 32'd1);
        check("b2b_r1_l1", {23'd0, q1[b1+1]}, 32'h102);
        check("b2b_r1_l2", {23'd0, q2[b2]},   32'h110);
        pulse_done();
        wait_ready("b2b_r2");
        check("b2b_r2_n1", q1.size() - b1, 32'd3);
        check("b2b_r2_n2", q2.size() - b2, 32'd4);
        check("b2b_r2_l1", {23'd0, q1[b1+2]}, 32'h103);
        check("b2b_r2_l2a", {23'd0, q2[b2+1]}, 32'h020);
        check("b2b_r2_l2c", {23'd0, q2[b2+3]}, 32'h122);
        pulse_done();
        repeat (10) begin @(posedge clk); #1; end
        check("b2b_idle", {31'd0, busy}, 32'd0);
        check("b2b_drained", q1.size() - b1, 32'd3);

`ifdef DUAL_STREAM_TX_TIMEOUT_EN
        // Timeout with done_i withheld
        begin
            int rc, tc;
            wr(1, 8'h44, 1'b1);
            wr(2, 8'h55, 1'b1);
            wait_ready("tmo");
            rc = 1; tc = 0;
            for (int k = 0; k < 30; k++) begin
                @(posedge clk); #1;
                rc += int'(tx_ready1);
                tc += int'(timeout_o);
            end
            check("tmo_cycles", rc, 32'd8);
            check("tmo_pulses", tc, 32'd1);
            check("tmo_idle", {31'd0, busy}, 32'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
